// File: rtl/ehgu_fifo_reader.sv
// Read-side engine for a single-clock FIFO memory: issues reads, absorbs memory latency, buffers words.
// Latency: waddr increment to dout_valid is 1 + READ_LAT cycles when idle with buffer space.
// Backpressure: credits (OUT_DEPTH - inflight - count) gate renable so the output buffer never overflows.
module ehgu_fifo_reader #(
   parameter int WIDTH     = 8,
   parameter int AWIDTH    = 8,
   parameter int DEPTH     = 128,
   parameter int READ_LAT  = 1,
   parameter int OUT_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [AWIDTH-1:0] waddr,
   output logic              renable,
   output logic [AWIDTH-1:0] raddr,
   input  logic [WIDTH-1:0]  rdata,
   output logic [WIDTH-1:0]  dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              empty,
   output logic [AWIDTH:0]   level
);

   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH + READ_LAT + 1) + 1;
   localparam logic [AWIDTH:0]   LP_DEPTH  = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH-1:0] LP_LAST   = AWIDTH'(DEPTH - 1);
   localparam logic [PW-1:0]     LP_OLAST  = PW'(OUT_DEPTH - 1);
   localparam logic [CW-1:0]     LP_ODEPTH = CW'(OUT_DEPTH);

   logic [AWIDTH-1:0]  r_raddr;
   logic [READ_LAT-1:0] r_vld;
   logic [WIDTH-1:0]   r_buf [OUT_DEPTH];
   logic [PW-1:0]      r_head;
   logic [PW-1:0]      r_tail;
   logic [CW-1:0]      r_count;

   logic [AWIDTH:0]    w_wa;
   logic [AWIDTH:0]    w_ra;
   logic [AWIDTH:0]    w_avail;
   logic [CW-1:0]      w_inflight;
   logic [CW-1:0]      w_used;
   logic               w_ren;
   logic               w_push;
   logic               w_pop;

   // Unread words in memory, with the pointer wrap at DEPTH (not necessarily a power of 2).
   always_comb begin
      w_wa    = {1'b0, waddr};
      w_ra    = {1'b0, r_raddr};
      w_avail = (waddr >= r_raddr) ? (w_wa - w_ra) : (w_wa + LP_DEPTH - w_ra);
   end

   // Reads in flight = set bits of the latency shift register.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < READ_LAT; i++) begin
         w_inflight = w_inflight + {{(CW-1){1'b0}}, r_vld[i]};
      end
   end

   // Issue a read only while a credit remains, so every issued word has a buffer slot waiting.
   always_comb begin
      w_used = w_inflight + r_count;
      w_ren  = !rst && en && (w_avail != '0) && (w_used < LP_ODEPTH);
      w_push = r_vld[READ_LAT-1];
      w_pop  = (r_count != '0) && dout_ready;
   end

   assign renable    = w_ren;
   assign raddr      = r_raddr;
   assign level      = w_avail;
   assign empty      = rst || (w_avail == '0);
   assign dout_valid = (r_count != '0);
   assign dout       = r_buf[r_head];

   // Read address advances once per issued read, wrapping at DEPTH-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_raddr <= '0;
      end else if (w_ren) begin
         r_raddr <= (r_raddr == LP_LAST) ? '0 : r_raddr + AWIDTH'(1);
      end
   end

   // Valid shift register tracking reads until their data appears on rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_ren;
         for (int i = 1; i < READ_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   // Circular output buffer; push and pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            r_buf[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_buf[r_tail] <= rdata;
            r_tail        <= (r_tail == LP_OLAST) ? '0 : r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= (r_head == LP_OLAST) ? '0 : r_head + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A push into a full buffer means the credit accounting is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && (r_count == LP_ODEPTH)));

endmodule
